// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop/lap/reset stopwatch sequencer with a BCD mm:ss.cc time base.
//
// Ports:
//   clk_in          system clock, rising-edge active
//   rst             asynchronous active-high reset
//   tick_100hz      100 Hz level from the prescaler, synchronous to clk_in
//   btn_start_stop  one-cycle debounced pulse; wins over btn_lap_reset
//   btn_lap_reset   one-cycle debounced pulse
//   cs_bcd          displayed centiseconds, BCD 00..99
//   sec_bcd         displayed seconds, BCD 00..59
//   min_bcd         displayed minutes, BCD 00..MAX_MIN
//   running         high in RUN or LAP
//   lap_active      high in LAP (display shows the frozen lap register)
//   ovf             overflow indication
//   state           IDLE=0, RUN=1, LAP=2, PAUSE=3
//
// Optional feature macro: SW_OVF_HALT_EN
//   defined   : overflow holds MAX_MIN:59.99, forces PAUSE, ovf sticky until PAUSE->IDLE clear;
//               start/stop is ignored while ovf is set.
//   undefined : overflow wraps to 00:00.00 and keeps counting; ovf is a one-cycle pulse.

module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned MAX_MIN  = 59
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       tick_100hz,
    input  logic       btn_start_stop,
    input  logic       btn_lap_reset,
    output logic [7:0] cs_bcd,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic       running,
    output logic       lap_active,
    output logic       ovf,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StLap   = 2'd2,
        StPause = 2'd3
    } state_e;

    localparam logic [7:0] DivLast   = 8'(TICK_DIV - 1);
    localparam logic [7:0] MaxMinBcd = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

    // Returns {wrap, next}: wrap is set when v is at its top value and rolls to 00.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        logic [8:0] r;
        if (v == top) begin
            r = 9'h000 | 9'h100;
        end else if (v[3:0] == 4'd9) begin
            r = {1'b0, v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    state_e     state_q, state_d;
    logic       tick_q;
    logic [7:0] div_q, div_d;
    logic [7:0] cs_q, cs_d, sec_q, sec_d, min_q, min_d;
    logic [7:0] lap_cs_q, lap_cs_d, lap_sec_q, lap_sec_d, lap_min_q, lap_min_d;
    logic       ovf_q, ovf_d;

    logic       tick_edge, cnt_en, cs_step, overflow, ss_ok, clear;
    logic       cs_wrap, sec_wrap, min_wrap;
    logic [7:0] cs_nx, sec_nx, min_nx;

    always_comb begin
        tick_edge = tick_100hz & ~tick_q;
        // Uses the registered state, so a tick coinciding with a stop press still counts.
        cnt_en    = tick_edge & ((state_q == StRun) | (state_q == StLap));

        div_d   = div_q;
        cs_step = 1'b0;
        if (cnt_en) begin
            if (div_q == DivLast) begin
                div_d   = '0;
                cs_step = 1'b1;
            end else begin
                div_d = div_q + 8'd1;
            end
        end

        {cs_wrap, cs_nx}   = bcd_inc(cs_q, 8'h99);
        {sec_wrap, sec_nx} = bcd_inc(sec_q, 8'h59);
        {min_wrap, min_nx} = bcd_inc(min_q, MaxMinBcd);
        overflow = cs_step & cs_wrap & sec_wrap & min_wrap;

        cs_d  = cs_q;
        sec_d = sec_q;
        min_d = min_q;
        if (cs_step) begin
            cs_d = cs_nx;
            if (cs_wrap) sec_d = sec_nx;
            if (cs_wrap && sec_wrap) min_d = min_nx;
        end

`ifdef SW_OVF_HALT_EN
        if (overflow) begin
            cs_d  = cs_q;
            sec_d = sec_q;
            min_d = min_q;
        end
        // ovf can only be set while parked in PAUSE, so this gates resume after overflow.
        ss_ok = ~ovf_q;
        ovf_d = ovf_q | overflow;
`else
        ss_ok = 1'b1;
        ovf_d = overflow;
`endif

        state_d   = state_q;
        lap_cs_d  = lap_cs_q;
        lap_sec_d = lap_sec_q;
        lap_min_d = lap_min_q;
        clear     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (btn_start_stop) state_d = StRun;
            end
            StRun: begin
                if (btn_start_stop) begin
                    state_d = StPause;
                end else if (btn_lap_reset) begin
                    state_d   = StLap;
                    // Capture the pre-increment value seen in this cycle.
                    lap_cs_d  = cs_q;
                    lap_sec_d = sec_q;
                    lap_min_d = min_q;
                end
            end
            StLap: begin
                if (btn_start_stop) state_d = StPause;
                else if (btn_lap_reset) state_d = StRun;
            end
            StPause: begin
                if (btn_start_stop && ss_ok) begin
                    state_d = StRun;
                end else if (btn_lap_reset) begin
                    state_d = StIdle;
                    clear   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef SW_OVF_HALT_EN
        if (overflow) state_d = StPause;
`endif

        if (clear) begin
            cs_d      = '0;
            sec_d     = '0;
            min_d     = '0;
            lap_cs_d  = '0;
            lap_sec_d = '0;
            lap_min_d = '0;
            div_d     = '0;
            ovf_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            tick_q    <= 1'b1;  // a tick already high at release is not an edge
            div_q     <= '0;
            cs_q      <= '0;
            sec_q     <= '0;
            min_q     <= '0;
            lap_cs_q  <= '0;
            lap_sec_q <= '0;
            lap_min_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_100hz;
            div_q     <= div_d;
            cs_q      <= cs_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            lap_cs_q  <= lap_cs_d;
            lap_sec_q <= lap_sec_d;
            lap_min_q <= lap_min_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state      = state_q;
        running    = (state_q == StRun) | (state_q == StLap);
        lap_active = (state_q == StLap);
        ovf        = ovf_q;
        cs_bcd     = lap_active ? lap_cs_q  : cs_q;
        sec_bcd    = lap_active ? lap_sec_q : sec_q;
        min_bcd    = lap_active ? lap_min_q : min_q;
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: two instances (TICK_DIV=1/MAX_MIN=1 and TICK_DIV=3/MAX_MIN=59)
// share stimulus; a reference model tracks elapsed time as a plain centisecond count.

module tb_stopwatch_ctrl;

    localparam int IDLE = 0, RUN = 1, LAP = 2, PAUSE = 3;
`ifdef SW_OVF_HALT_EN
    localparam bit Halt = 1'b1;
`else
    localparam bit Halt = 1'b0;
`endif

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b1;
    logic       btn_ss = 1'b0;
    logic       btn_lr = 1'b0;
    logic [7:0] cs_o[2], sec_o[2], min_o[2];
    logic       run_o[2], lap_o[2], ovf_o[2];
    logic [1:0] st_o[2];

    int vectors = 0;
    int miscompares = 0;

    int td[2] = '{1, 3};
    int mm[2] = '{1, 59};
    int m_st[2], m_cnt[2], m_lap[2], m_div[2];
    bit m_ovf[2];
    bit m_tick_prev;

    always #5 clk_in = ~clk_in;

    stopwatch_ctrl #(.TICK_DIV(1), .MAX_MIN(1)) u_dut0 (
        .clk_in(clk_in), .rst(rst), .tick_100hz(tick),
        .btn_start_stop(btn_ss), .btn_lap_reset(btn_lr),
        .cs_bcd(cs_o[0]), .sec_bcd(sec_o[0]), .min_bcd(min_o[0]),
        .running(run_o[0]), .lap_active(lap_o[0]), .ovf(ovf_o[0]), .state(st_o[0])
    );

    stopwatch_ctrl #(.TICK_DIV(3), .MAX_MIN(59)) u_dut1 (
        .clk_in(clk_in), .rst(rst), .tick_100hz(tick),
        .btn_start_stop(btn_ss), .btn_lap_reset(btn_lr),
        .cs_bcd(cs_o[1]), .sec_bcd(sec_o[1]), .min_bcd(min_o[1]),
        .running(run_o[1]), .lap_active(lap_o[1]), .ovf(ovf_o[1]), .state(st_o[1])
    );

    function automatic logic [7:0] to_bcd(int x);
        logic [3:0] t, u;
        t = 4'(x / 10);
        u = 4'(x % 10);
        return {t, u};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = IDLE; m_cnt[i] = 0; m_lap[i] = 0; m_div[i] = 0; m_ovf[i] = 1'b0;
        end
        m_tick_prev = 1'b1;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        bit rise;
        rise = tick && !m_tick_prev;
        for (int i = 0; i < 2; i++) begin
            int  old_cnt, top, nst;
            bit  inc, oevt, ss, lr, clr;
            old_cnt = m_cnt[i];
            top     = mm[i] * 6000 + 5999;
            inc     = 1'b0;
            clr     = 1'b0;
            if (rise && (m_st[i] == RUN || m_st[i] == LAP)) begin
                m_div[i]++;
                if (m_div[i] == td[i]) begin
                    m_div[i] = 0;
                    inc = 1'b1;
                end
            end
            oevt = inc && (old_cnt == top);
            if (inc) begin
                if (oevt) begin
                    if (!Halt) m_cnt[i] = 0;
                end else begin
                    m_cnt[i] = old_cnt + 1;
                end
            end
            ss = btn_ss;
            lr = btn_lr && !btn_ss;
            if (Halt && m_st[i] == PAUSE && m_ovf[i]) begin
                ss = 1'b0;
                lr = btn_lr;
            end
            nst = m_st[i];
            case (m_st[i])
                IDLE:  if (ss) nst = RUN;
                RUN: begin
                    if (ss) nst = PAUSE;
                    else if (lr) begin nst = LAP; m_lap[i] = old_cnt; end
                end
                LAP:   if (ss) nst = PAUSE; else if (lr) nst = RUN;
                default: if (ss) nst = RUN; else if (lr) begin nst = IDLE; clr = 1'b1; end
            endcase
            if (Halt) begin
                if (oevt) begin m_ovf[i] = 1'b1; nst = PAUSE; end
            end else begin
                m_ovf[i] = oevt;
            end
            if (clr) begin
                m_cnt[i] = 0; m_lap[i] = 0; m_div[i] = 0; m_ovf[i] = 1'b0;
            end
            m_st[i] = nst;
        end
        m_tick_prev = tick;
    endtask

    task automatic chk(string tag, int i, logic [7:0] obs, logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s[%0d] observed=%h expected=%h at %0t", tag, i, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int c;
            c = (m_st[i] == LAP) ? m_lap[i] : m_cnt[i];
            chk("state", i, {6'd0, st_o[i]}, 8'(m_st[i]));
            chk("running", i, {7'd0, run_o[i]}, (m_st[i] == RUN || m_st[i] == LAP) ? 8'd1 : 8'd0);
            chk("lap_active", i, {7'd0, lap_o[i]}, (m_st[i] == LAP) ? 8'd1 : 8'd0);
            chk("ovf", i, {7'd0, ovf_o[i]}, {7'd0, m_ovf[i]});
            chk("cs", i, cs_o[i], to_bcd(c % 100));
            chk("sec", i, sec_o[i], to_bcd((c / 100) % 60));
            chk("min", i, min_o[i], to_bcd(c / 6000));
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        model_step();
        #1;
        check_all();
        btn_ss = 1'b0;
        btn_lr = 1'b0;
    endtask

    task automatic tick_edges(int n);
        for (int k = 0; k < n; k++) begin
            tick = 1'b1; step();
            tick = 1'b0; step();
        end
    endtask

    task automatic chk_time(string tag, logic [7:0] m, logic [7:0] s, logic [7:0] c);
        chk({tag, "_min"}, 0, min_o[0], m);
        chk({tag, "_sec"}, 0, sec_o[0], s);
        chk({tag, "_cs"}, 0, cs_o[0], c);
    endtask

    initial begin
        model_reset();
        #23 rst = 1'b0;
        #1 check_all();

        // Tick high at release is not an edge; three later edges in IDLE do not count.
        tick_edges(4);
        chk_time("idle", 8'h00, 8'h00, 8'h00);

        btn_ss = 1'b1; step();
        tick_edges(5);
        chk_time("run5", 8'h00, 8'h00, 8'h05);

        // Tick edge and stop in the same cycle: the tick still counts.
        tick = 1'b1; btn_ss = 1'b1; step();
        chk_time("tick_stop", 8'h00, 8'h00, 8'h06);
        chk("tick_stop_state", 0, {6'd0, st_o[0]}, 8'd3);
        tick = 1'b0; step();

        // Both buttons in PAUSE: start/stop wins, no clear.
        btn_ss = 1'b1; btn_lr = 1'b1; step();
        chk("both_state", 0, {6'd0, st_o[0]}, 8'd1);
        chk_time("both", 8'h00, 8'h00, 8'h06);

        tick_edges(144);
        chk_time("t150", 8'h00, 8'h01, 8'h50);
        chk("t150_running", 0, {7'd0, run_o[0]}, 8'd1);

        tick_edges(87);
        btn_lr = 1'b1; step();
        chk_time("lap", 8'h00, 8'h02, 8'h37);
        chk("lap_active", 0, {7'd0, lap_o[0]}, 8'd1);
        tick_edges(10);
        chk_time("lap_frozen", 8'h00, 8'h02, 8'h37);
        btn_lr = 1'b1; step();
        chk_time("lap_release", 8'h00, 8'h02, 8'h47);

        tick_edges(5752);
        chk_time("pre_min", 8'h00, 8'h59, 8'h99);
        tick = 1'b1; step();
        chk_time("min_carry", 8'h01, 8'h00, 8'h00);
        tick = 1'b0; step();

        tick_edges(5999);
        chk_time("pre_ovf", 8'h01, 8'h59, 8'h99);
        tick = 1'b1; step();
`ifdef SW_OVF_HALT_EN
        chk_time("ovf_hold", 8'h01, 8'h59, 8'h99);
        chk("ovf_state", 0, {6'd0, st_o[0]}, 8'd3);
        chk("ovf_set", 0, {7'd0, ovf_o[0]}, 8'd1);
        tick = 1'b0; step();
        chk("ovf_sticky", 0, {7'd0, ovf_o[0]}, 8'd1);
        btn_ss = 1'b1; step();
        chk("ovf_ss_ignored", 0, {6'd0, st_o[0]}, 8'd3);
`else
        chk_time("ovf_wrap", 8'h00, 8'h00, 8'h00);
        chk("ovf_pulse", 0, {7'd0, ovf_o[0]}, 8'd1);
        chk("ovf_state", 0, {6'd0, st_o[0]}, 8'd1);
        tick = 1'b0; step();
        chk("ovf_pulse_end", 0, {7'd0, ovf_o[0]}, 8'd0);
        btn_ss = 1'b1; step();
`endif
        btn_lr = 1'b1; step();
        chk("cleared_state", 0, {6'd0, st_o[0]}, 8'd0);
        chk("cleared_ovf", 0, {7'd0, ovf_o[0]}, 8'd0);
        chk_time("cleared", 8'h00, 8'h00, 8'h00);

        // Asynchronous reset in the middle of counting.
        btn_ss = 1'b1; step();
        tick_edges(37);
        @(posedge clk_in);
        model_step();
        #3 rst = 1'b1;
        tick = 1'b1;
        #1 model_reset();
        check_all();
        @(posedge clk_in);
        #1 check_all();
        #2 rst = 1'b0;
        step();

        // Randomised phase: arbitrary tick levels and sparse button pulses.
        for (int k = 0; k < 3000; k++) begin
            tick   = 1'($urandom_range(0, 1));
            btn_ss = ($urandom_range(0, 15) == 0);
            btn_lr = ($urandom_range(0, 11) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
